// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the lockstep sequencer: default sizes and the
// sequencer state encoding.
package fsm_seq_pkg;

    // Longest pattern that can be played, in bits
    localparam int unsigned MAX_LEN = 16;
    // Width of len / index / count fields; must be able to hold MAX_LEN
    localparam int unsigned LEN_W   = 5;
    // Width of the one-hot FSM state vector under observation
    localparam int unsigned OH_W    = 5;

    // One step of the pattern walks DRIVE -> STEP -> SETTLE -> COMPARE
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRIVE,
        STEP,
        SETTLE,
        COMPARE,
        DONE
    } seqState_e;

endpackage

// File: rtl/onehot_check.sv
// Combinational legality check for a one-hot state vector: legal only when
// exactly one bit is set (all-zero and multi-hot are both illegal).
module onehot_check #(
    parameter int unsigned OH_W = fsm_seq_pkg::OH_W
) (
    input  logic [OH_W-1:0] state_i,
    output logic            legal_o
);
    import fsm_seq_pkg::*;

    localparam int unsigned CNT_W = $clog2(OH_W + 1);

    logic [CNT_W-1:0] bitCount;

    // Population count of the state vector, then compare against one
    always_comb begin
        bitCount = '0;
        for (int unsigned i = 0; i < OH_W; i++) begin
            bitCount = bitCount + CNT_W'(state_i[i]);
        end
        legal_o = (bitCount == CNT_W'(1));
    end

endmodule

// File: rtl/fsm_lockstep_sequencer.sv
// Plays a latched bit pattern into two sequence-detector FSMs (binary and
// one-hot encodings) one bit per step, then compares their z outputs and the
// one-hot state legality after each step. Reports a saturating failure count
// and the index of the first failing step.
module fsm_lockstep_sequencer #(
    parameter int unsigned MAX_LEN = fsm_seq_pkg::MAX_LEN,
    parameter int unsigned LEN_W   = fsm_seq_pkg::LEN_W,
    parameter int unsigned OH_W    = fsm_seq_pkg::OH_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               w_out,
    output logic               fsm_en,
    output logic               fsm_rst,
    input  logic               z_bin,
    input  logic               z_oh,
    input  logic [OH_W-1:0]    state_oh,
    output logic               busy,
    output logic               done,
    output logic [LEN_W-1:0]   err_count,
    output logic [LEN_W-1:0]   first_err_idx
);
    import fsm_seq_pkg::*;

    // Bit-select width into the pattern; idx never reaches MAX_LEN when used
    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    seqState_e          stateQ;
    logic [MAX_LEN-1:0] patternQ;
    logic [LEN_W-1:0]   lenQ;
    logic [LEN_W-1:0]   idxQ;

    logic               ohLegal;
    logic               stepFail;
    logic               lastStep;
    logic [LEN_W-1:0]   lenClamped;
    logic [LEN_W-1:0]   idxInc;
    logic [IDX_W-1:0]   nextBit;

    onehot_check #(
        .OH_W (OH_W)
    ) uOnehotCheck (
        .state_i (state_oh),
        .legal_o (ohLegal)
    );

    // Run-control helpers: length clamp, step verdict and end-of-run detect
    always_comb begin
        lenClamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
        // A z mismatch and an illegal one-hot state in the same step count once
        stepFail   = (z_bin != z_oh) || !ohLegal;
        idxInc     = idxQ + LEN_W'(1);
        lastStep   = (idxInc == lenQ);
        nextBit    = idxInc[IDX_W-1:0];
    end

    // Sequencer FSM with registered outputs, index and error bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ        <= IDLE;
            patternQ      <= '0;
            lenQ          <= '0;
            idxQ          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fsm_en        <= 1'b0;
            fsm_rst       <= 1'b1;
            w_out         <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            // Single-cycle strobes default low every cycle
            fsm_en  <= 1'b0;
            fsm_rst <= 1'b0;
            done    <= 1'b0;
            unique case (stateQ)
                IDLE: begin
                    if (start) begin
                        patternQ      <= pattern;
                        lenQ          <= lenClamped;
                        idxQ          <= '0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                        fsm_rst       <= 1'b1;
                        busy          <= 1'b1;
                        stateQ        <= LOAD;
                    end
                end
                LOAD: begin
                    if (lenQ == '0) begin
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        stateQ <= DONE;
                    end else begin
                        w_out  <= patternQ[0];
                        stateQ <= DRIVE;
                    end
                end
                DRIVE: begin
                    fsm_en <= 1'b1;
                    stateQ <= STEP;
                end
                STEP: begin
                    stateQ <= SETTLE;
                end
                SETTLE: begin
                    // Both FSMs register z on the STEP edge; give it a cycle
                    stateQ <= COMPARE;
                end
                COMPARE: begin
                    if (stepFail) begin
                        if (err_count != '1) begin
                            err_count <= err_count + LEN_W'(1);
                        end
                        if (err_count == '0) begin
                            first_err_idx <= idxQ;
                        end
                    end
                    idxQ <= idxInc;
                    if (lastStep) begin
                        w_out  <= 1'b0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        stateQ <= DONE;
                    end else begin
                        w_out  <= patternQ[nextBit];
                        stateQ <= DRIVE;
                    end
                end
                DONE: begin
                    stateQ <= IDLE;
                end
                default: begin
                    stateQ <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_lockstep_sequencer.sv
// Scoreboard bench for fsm_lockstep_sequencer. Stimulus pushes the expected
// w_out per step and the expected run result; a monitor pops and compares
// whenever fsm_en or done is presented. A small stub stands in for the two
// FSMs and injects z mismatches / illegal one-hot states on chosen steps.
module tb_fsm_lockstep_sequencer;

    localparam time PERIOD = 10;
    localparam time HALF   = 5;

    typedef struct {
        int err;
        int first;
        int lat;
        int steps;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] pattern = '0;
    logic [4:0]  len = '0;
    logic        w_out;
    logic        fsm_en;
    logic        fsm_rst;
    logic        z_bin;
    logic        z_oh;
    logic [4:0]  state_oh;
    logic        busy;
    logic        done;
    logic [4:0]  err_count;
    logic [4:0]  first_err_idx;

    int          passCnt = 0;
    int          totalCnt = 0;
    int          doneCount = 0;
    int          stepsSeen = 0;
    int          stubIdx = 0;
    time         startT = 0;
    logic [15:0] zMask = '0;
    logic [15:0] ohMask = '0;
    logic        stepQ[$];
    res_t        resQ[$];
    res_t        r;

    fsm_lockstep_sequencer #(
        .MAX_LEN (16),
        .LEN_W   (5),
        .OH_W    (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .pattern       (pattern),
        .len           (len),
        .w_out         (w_out),
        .fsm_en        (fsm_en),
        .fsm_rst       (fsm_rst),
        .z_bin         (z_bin),
        .z_oh          (z_oh),
        .state_oh      (state_oh),
        .busy          (busy),
        .done          (done),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    always #HALF clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // Stand-in for the two detector FSMs: after each fsm_en edge, present z
    // (optionally mismatched) and a one-hot state (optionally illegal).
    initial begin
        int k;
        z_bin    = 1'b0;
        z_oh     = 1'b0;
        state_oh = 5'b00001;
        forever begin
            @(negedge clk);
            if (reset || fsm_rst) begin
                stubIdx = 0;
            end else if (fsm_en) begin
                k = stubIdx;
                stubIdx++;
                @(posedge clk);
                #1;
                z_bin    = w_out;
                z_oh     = w_out ^ zMask[k];
                state_oh = ohMask[k] ? 5'b00110 : 5'b00001;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a step or a result
    always @(negedge clk) begin
        if (reset) begin
            stepsSeen = 0;
        end else begin
            if (fsm_en) begin
                stepsSeen++;
                check("step pending", {31'd0, stepQ.size() != 0}, 32'd1);
                check("fsm_rst low at step", 32'(fsm_rst), 32'd0);
                if (stepQ.size() != 0) check("w_out at step", 32'(w_out), 32'(stepQ.pop_front()));
            end
            if (done) begin
                doneCount++;
                check("result pending", {31'd0, resQ.size() != 0}, 32'd1);
                if (resQ.size() != 0) begin
                    r = resQ.pop_front();
                    check("err_count", 32'(err_count), 32'(r.err));
                    check("first_err_idx", 32'(first_err_idx), 32'(r.first));
                    check("done latency", 32'((($time - startT) + HALF) / PERIOD), 32'(r.lat));
                    check("fsm_en pulses", 32'(stepsSeen), 32'(r.steps));
                    check("busy low at done", 32'(busy), 32'd0);
                end
            end
            if (fsm_rst) stepsSeen = 0;
        end
    end

    // Queue expectations for one run, then issue start for one cycle
    task automatic runSeq(input logic [15:0] pat, input int l, input logic [15:0] zm,
                          input logic [15:0] om, input int expErr, input int expFirst);
        int effLen;
        res_t e;
        effLen = (l > 16) ? 16 : l;
        for (int i = 0; i < effLen; i++) stepQ.push_back(pat[i]);
        e.err   = expErr;
        e.first = expFirst;
        e.lat   = 4 * effLen + 2;
        e.steps = effLen;
        resQ.push_back(e);
        zMask  = zm;
        ohMask = om;
        @(negedge clk);
        pattern = pat;
        len     = 5'(l);
        start   = 1'b1;
        @(posedge clk);
        startT = $time;
        @(negedge clk);
        start = 1'b0;
        check("busy in LOAD", 32'(busy), 32'd1);
        check("fsm_rst in LOAD", 32'(fsm_rst), 32'd1);
    endtask

    task automatic waitDone(input int budget);
        int prev;
        int c;
        prev = doneCount;
        c = 0;
        while (doneCount == prev && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        check("done within budget", 32'(doneCount - prev), 32'd1);
        check("steps consumed", 32'(stepQ.size()), 32'd0);
    endtask

    initial begin
        int pulses;
        int prevDone;

        // Reset held, then released
        repeat (3) @(negedge clk);
        check("reset fsm_rst", 32'(fsm_rst), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset fsm_en", 32'(fsm_en), 32'd0);
        check("reset w_out", 32'(w_out), 32'd0);
        check("reset err_count", 32'(err_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle fsm_rst", 32'(fsm_rst), 32'd0);
        check("idle busy", 32'(busy), 32'd0);

        // Clean 8-bit run: w sequence 1,0,1,0,1,1,0,1, done 34 cycles after start
        runSeq(16'h00B5, 8, 16'h0000, 16'h0000, 0, 0);
        waitDone(100);

        // z mismatch on steps 2 and 4; results hold while idle
        runSeq(16'h002D, 6, 16'h0014, 16'h0000, 2, 2);
        waitDone(100);
        pattern = 16'hFFFF;
        len     = 5'd3;
        repeat (5) @(negedge clk);
        check("hold err_count", 32'(err_count), 32'd2);
        check("hold first_err_idx", 32'(first_err_idx), 32'd2);

        // Illegal one-hot on step 1, then same step with z also mismatched
        runSeq(16'h0009, 4, 16'h0000, 16'h0002, 1, 1);
        waitDone(100);
        runSeq(16'h0006, 4, 16'h0002, 16'h0002, 1, 1);
        waitDone(100);

        // Every step fails: first failure at index 0
        runSeq(16'h0013, 5, 16'h001F, 16'h0000, 5, 0);
        waitDone(100);

        // len 0 and clamped len 20
        runSeq(16'hFFFF, 0, 16'h0000, 16'h0000, 0, 0);
        waitDone(20);
        runSeq(16'hA5C3, 20, 16'h0000, 16'h0000, 0, 0);
        waitDone(200);

        // Reset during STEP of step 3: immediate reset values, no done pulse
        prevDone = doneCount;
        runSeq(16'h00B5, 8, 16'h0000, 16'h0000, 0, 0);
        pulses = 0;
        for (int c = 0; c < 100 && pulses < 4; c++) begin
            @(negedge clk);
            if (fsm_en) pulses++;
        end
        check("reached step 3", 32'(pulses), 32'd4);
        #1;
        reset = 1'b1;
        #1;
        check("abort fsm_en", 32'(fsm_en), 32'd0);
        check("abort fsm_rst", 32'(fsm_rst), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        check("abort w_out", 32'(w_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        stepQ.delete();
        resQ.delete();
        @(negedge clk);
        #1;
        check("post-abort fsm_rst", 32'(fsm_rst), 32'd0);
        check("post-abort busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        check("no done after abort", 32'(doneCount - prevDone), 32'd0);

        // Fresh run from idx 0; start, pattern and len changes mid-run ignored
        runSeq(16'h0F0F, 6, 16'h0001, 16'h0000, 1, 0);
        repeat (5) @(negedge clk);
        start   = 1'b1;
        pattern = 16'hFFFF;
        len     = 5'd2;
        @(negedge clk);
        start = 1'b0;
        check("busy mid-run", 32'(busy), 32'd1);
        waitDone(100);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passCnt, totalCnt);
        $fatal(1, "timeout");
    end

endmodule
